// File: rtl/cmd_frame_ctrl.sv
// Command frame controller: decodes RX command frames into register writes/reads and ALU ops, then returns results over a Busy-handshaked TX port.
// Optional macro CMD_TIMEOUT_EN drops an incomplete frame after TIMEOUT_CYCLES idle cycles.
module cmd_frame_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int OUT_WORDS      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [DATA_WIDTH-1:0]           RX_P_DATA,
  input  logic                            RX_D_VLD,
  input  logic [OUT_WORDS*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                            ALU_OUT_VLD,
  input  logic [DATA_WIDTH-1:0]           RdData,
  input  logic                            RdData_VLD,
  input  logic                            Busy,
  output logic [3:0]                      ALU_FUN,
  output logic                            ALU_EN,
  output logic                            CLK_EN,
  output logic [ADDR_WIDTH-1:0]           Address,
  output logic                            WrEn,
  output logic                            RdEn,
  output logic [DATA_WIDTH-1:0]           WrData,
  output logic [DATA_WIDTH-1:0]           TX_P_DATA,
  output logic                            TX_D_VLD,
  output logic                            CLK_div_en,
  output logic                            Frame_error
);

  localparam int CW = $clog2(OUT_WORDS + 1);
  localparam int BW = OUT_WORDS * DATA_WIDTH;

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, OP_FUN, ALU_WAIT, TX_SEND, TX_HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
  logic                  wren_q, wren_d, rden_q, rden_d;
  logic [3:0]            alu_fun_q, alu_fun_d;
  logic                  alu_en_q, alu_en_d, clk_en_q, clk_en_d;
  logic                  ferr_q, ferr_d, div_en_q;
  logic [BW-1:0]         txbuf_q, txbuf_d, tx_shift;
  logic [CW-1:0]         nwords_q, nwords_d, cnt_q, cnt_d;
  logic                  upper_zero;

  assign upper_zero = ((RX_P_DATA >> 8) == '0);
  assign tx_shift   = txbuf_q >> (int'(cnt_q) * DATA_WIDTH);

`ifdef CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          in_frame;
  assign in_frame = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR) ||
                    (state_q == OP_A) || (state_q == OP_B) || (state_q == OP_FUN);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wrdata_d  = wrdata_q;
    wren_d    = 1'b0;
    rden_d    = 1'b0;
    alu_fun_d = alu_fun_q;
    alu_en_d  = 1'b0;
    clk_en_d  = clk_en_q;
    ferr_d    = 1'b0;
    txbuf_d   = txbuf_q;
    nwords_d  = nwords_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: if (RX_D_VLD) begin
        if (!upper_zero) ferr_d = 1'b1;
        else begin
          case (RX_P_DATA[7:0])
            8'hAA:   state_d = WR_ADDR;
            8'hBB:   state_d = RD_ADDR;
            8'hCC:   state_d = OP_A;
            8'hDD:   begin state_d = OP_FUN; clk_en_d = 1'b1; end
            default: ferr_d = 1'b1;
          endcase
        end
      end
      WR_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        wrdata_d = RX_P_DATA;
        wren_d   = 1'b1;
        state_d  = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        rden_d  = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: if (RdData_VLD) begin
        txbuf_d                   = '0;
        txbuf_d[DATA_WIDTH-1:0]   = RdData;
        nwords_d                  = CW'(1);
        cnt_d                     = '0;
        // TX_SEND may only be entered with Busy low; otherwise park in TX_HOLD first
        state_d                   = Busy ? TX_HOLD : TX_SEND;
      end
      OP_A: if (RX_D_VLD) begin
        addr_d   = '0;
        wrdata_d = RX_P_DATA;
        wren_d   = 1'b1;
        state_d  = OP_B;
      end
      OP_B: if (RX_D_VLD) begin
        addr_d   = ADDR_WIDTH'(1);
        wrdata_d = RX_P_DATA;
        wren_d   = 1'b1;
        clk_en_d = 1'b1;
        state_d  = OP_FUN;
      end
      OP_FUN: if (RX_D_VLD) begin
        alu_fun_d = RX_P_DATA[3:0];
        alu_en_d  = 1'b1;
        state_d   = ALU_WAIT;
      end
      ALU_WAIT: if (ALU_OUT_VLD) begin
        txbuf_d  = ALU_OUT;
        nwords_d = CW'(OUT_WORDS);
        cnt_d    = '0;
        clk_en_d = 1'b0;
        state_d  = Busy ? TX_HOLD : TX_SEND;
      end
      TX_SEND: if (Busy) begin
        cnt_d   = cnt_q + CW'(1);
        state_d = TX_HOLD;
      end
      TX_HOLD: if (!Busy) begin
        if (cnt_q == nwords_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          state_d = TX_SEND;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef CMD_TIMEOUT_EN
    tmo_d = (!in_frame || RX_D_VLD) ? '0 : tmo_q + TW'(1);
    if (in_frame && !RX_D_VLD && (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
      tmo_d    = '0;
      state_d  = IDLE;
      ferr_d   = 1'b1;
      clk_en_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wrdata_q  <= '0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      alu_fun_q <= '0;
      alu_en_q  <= 1'b0;
      clk_en_q  <= 1'b0;
      ferr_q    <= 1'b0;
      div_en_q  <= 1'b0;
      txbuf_q   <= '0;
      nwords_q  <= '0;
      cnt_q     <= '0;
`ifdef CMD_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
      alu_fun_q <= alu_fun_d;
      alu_en_q  <= alu_en_d;
      clk_en_q  <= clk_en_d;
      ferr_q    <= ferr_d;
      div_en_q  <= 1'b1;
      txbuf_q   <= txbuf_d;
      nwords_q  <= nwords_d;
      cnt_q     <= cnt_d;
`ifdef CMD_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign ALU_FUN     = alu_fun_q;
  assign ALU_EN      = alu_en_q;
  assign CLK_EN      = clk_en_q;
  assign Address     = addr_q;
  assign WrEn        = wren_q;
  assign RdEn        = rden_q;
  assign WrData      = wrdata_q;
  assign TX_P_DATA   = tx_shift[DATA_WIDTH-1:0];
  assign TX_D_VLD    = (state_q == TX_SEND);
  assign CLK_div_en  = div_en_q;
  assign Frame_error = ferr_q;

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Randomized self-checking bench for cmd_frame_ctrl: frames are scored against per-frame expected transaction queues.
module tb_cmd_frame_ctrl;
  localparam int DW = 8, AW = 4, OW = 2, TC = 16;

  logic          CLK, RST;
  logic [DW-1:0] RX_P_DATA, RdData, WrData, TX_P_DATA;
  logic          RX_D_VLD, ALU_OUT_VLD, RdData_VLD, Busy;
  logic [OW*DW-1:0] ALU_OUT;
  logic [3:0]    ALU_FUN;
  logic          ALU_EN, CLK_EN, WrEn, RdEn, TX_D_VLD, CLK_div_en, Frame_error;
  logic [AW-1:0] Address;

  cmd_frame_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_WORDS(OW), .TIMEOUT_CYCLES(TC)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .RdData(RdData), .RdData_VLD(RdData_VLD),
    .Busy(Busy), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_EN(CLK_EN), .Address(Address),
    .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .CLK_div_en(CLK_div_en), .Frame_error(Frame_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected (model) and observed transactions for the frame in progress
  logic [15:0] wr_got[$], wr_exp[$];
  logic [7:0]  rd_got[$], rd_exp[$], tx_got[$], tx_exp[$];
  logic [3:0]  fun_got[$], fun_exp[$];
  int ferr_got = 0, ferr_exp = 0, both_cnt = 0;
  bit tx_stall = 1'b0;

  function automatic logic [63:0] outs();
    return 64'({ALU_FUN, ALU_EN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_DATA,
                TX_D_VLD, CLK_div_en, Frame_error});
  endfunction

  always @(negedge CLK) begin
    if (RST) begin
      if (WrEn) wr_got.push_back({4'h0, Address, WrData});
      if (RdEn) rd_got.push_back({4'h0, Address});
      if (ALU_EN) fun_got.push_back(ALU_FUN);
      if (Frame_error) ferr_got++;
      if (WrEn && RdEn) both_cnt++;
    end
  end

  // Transmitter model: accepts a word, holds off Busy a random time, then stays busy a random time
  initial begin
    logic [7:0] w;
    int d, h;
    Busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST && !tx_stall && TX_D_VLD && !Busy) begin
        w = TX_P_DATA;
        tx_got.push_back(w);
        d = $urandom_range(0, 2);
        repeat (d) begin
          @(negedge CLK);
          if (!RST) break;
          check("tx_vld_held", 64'(TX_D_VLD), 64'd1);
          check("tx_data_held", 64'(TX_P_DATA), 64'(w));
        end
        Busy = 1'b1;
        h = $urandom_range(1, 3);
        repeat (h) begin
          @(negedge CLK);
          if (!RST) break;
          check("tx_vld_while_busy", 64'(TX_D_VLD), 64'd0);
        end
        Busy = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_word(input logic [7:0] w);
    RX_P_DATA = w;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'($urandom);
  endtask

  task automatic gap();
    tick($urandom_range(0, 2));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(tx_got.size() == tx_exp.size() && !Busy && !TX_D_VLD) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("done_timeout", 64'd1, 64'd0);
    tick(3);
  endtask

  task automatic compare_all();
    check("wr_count", 64'(wr_got.size()), 64'(wr_exp.size()));
    while (wr_got.size() > 0 && wr_exp.size() > 0) check("wr_entry", 64'(wr_got.pop_front()), 64'(wr_exp.pop_front()));
    check("rd_count", 64'(rd_got.size()), 64'(rd_exp.size()));
    while (rd_got.size() > 0 && rd_exp.size() > 0) check("rd_addr", 64'(rd_got.pop_front()), 64'(rd_exp.pop_front()));
    check("alu_count", 64'(fun_got.size()), 64'(fun_exp.size()));
    while (fun_got.size() > 0 && fun_exp.size() > 0) check("alu_fun", 64'(fun_got.pop_front()), 64'(fun_exp.pop_front()));
    check("tx_count", 64'(tx_got.size()), 64'(tx_exp.size()));
    while (tx_got.size() > 0 && tx_exp.size() > 0) check("tx_word", 64'(tx_got.pop_front()), 64'(tx_exp.pop_front()));
    check("frame_error_count", 64'(ferr_got), 64'(ferr_exp));
    wr_got.delete(); wr_exp.delete(); rd_got.delete(); rd_exp.delete();
    fun_got.delete(); fun_exp.delete(); tx_got.delete(); tx_exp.delete();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    send_word(8'hAA); gap();
    send_word({4'h0, a}); gap();
    send_word(d);
    wr_exp.push_back({4'h0, a, d});
    wait_done();
    compare_all();
  endtask

  task automatic wait_rden();
    int n = 0;
    while (!RdEn && n < 10) begin tick(); n++; end
    if (!RdEn) check("rden_seen", 64'd0, 64'd1);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] rd, input bit inject);
    send_word(8'hBB); gap();
    send_word({4'h0, a});
    wait_rden();
    if (inject) send_word(8'($urandom)); else tick();
    RdData = rd; RdData_VLD = 1'b1;
    tick();
    RdData_VLD = 1'b0; RdData = 8'($urandom);
    rd_exp.push_back({4'h0, a});
    tx_exp.push_back(rd);
    wait_done();
    compare_all();
  endtask

  task automatic do_alu(input bit ops, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] f, input logic [15:0] res, input bit inject);
    int n = 0;
    if (ops) begin
      send_word(8'hCC); gap();
      send_word(a); gap();
      send_word(b);
      wr_exp.push_back({8'h00, a});
      wr_exp.push_back({8'h01, b});
    end else begin
      send_word(8'hDD);
    end
    check("clk_en_opfun", 64'(CLK_EN), 64'd1);
    gap();
    send_word({4'($urandom), f});
    fun_exp.push_back(f);
    while (!ALU_EN && n < 10) begin tick(); n++; end
    if (!ALU_EN) check("alu_en_seen", 64'd0, 64'd1);
    if (inject) send_word(8'($urandom));
    tick($urandom_range(0, 3));
    check("clk_en_alu_wait", 64'(CLK_EN), 64'd1);
    ALU_OUT = res; ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0; ALU_OUT = 16'($urandom);
    tx_exp.push_back(res[7:0]);
    tx_exp.push_back(res[15:8]);
    wait_done();
    check("clk_en_done", 64'(CLK_EN), 64'd0);
    compare_all();
  endtask

  task automatic do_bad(input logic [7:0] c);
    send_word(c);
    ferr_exp++;
    tick(2);
    compare_all();
  endtask

  task automatic do_spurious();
    RdData_VLD = 1'b1; ALU_OUT_VLD = 1'b1;
    tick();
    RdData_VLD = 1'b0; ALU_OUT_VLD = 1'b0;
    tick(3);
    compare_all();
  endtask

  initial begin
    logic [7:0] c;
    int n;
    RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; ALU_OUT = '0; ALU_OUT_VLD = 1'b0;
    RdData = '0; RdData_VLD = 1'b0;
    tick(2);
    check("reset_outputs", outs(), 64'd0);
    RST = 1'b1;
    tick();
    check("div_en_after_reset", 64'(CLK_div_en), 64'd1);

    do_write(4'h5, 8'h3C);
    do_read(4'h2, 8'h7E, 1'b0);
    do_alu(1'b1, 8'h0A, 8'h03, 4'h2, 16'h001E, 1'b0);
    do_bad(8'h55);
    do_write(4'hF, 8'hA5);
    do_spurious();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: do_write(4'($urandom), 8'($urandom));
        1: do_read(4'($urandom), 8'($urandom), 1'($urandom));
        2: do_alu(1'b1, 8'($urandom), 8'($urandom), 4'($urandom), 16'($urandom), 1'($urandom));
        3: do_alu(1'b0, 8'h00, 8'h00, 4'($urandom), 16'($urandom), 1'($urandom));
        4: begin
          do c = 8'($urandom); while (c == 8'hAA || c == 8'hBB || c == 8'hCC || c == 8'hDD);
          do_bad(c);
        end
        default: do_spurious();
      endcase
    end

`ifdef CMD_TIMEOUT_EN
    send_word(8'hAA); send_word(8'h01);
    tick(TC + 4);
    ferr_exp++;
    compare_all();
    do_read(4'h3, 8'h5A, 1'b0);
`endif

    // Reset in the middle of a transmission
    tx_stall = 1'b1;
    send_word(8'hBB);
    send_word(8'h04);
    wait_rden();
    tick();
    RdData = 8'hC3; RdData_VLD = 1'b1;
    tick();
    RdData_VLD = 1'b0;
    n = 0;
    while (!TX_D_VLD && n < 10) begin tick(); n++; end
    check("tx_vld_before_reset", 64'(TX_D_VLD), 64'd1);
    #2 RST = 1'b0;
    #1 check("reset_async_outputs", outs(), 64'd0);
    tick(2);
    RST = 1'b1;
    tick();
    check("div_en_after_rerun", 64'(CLK_div_en), 64'd1);
    check("tx_idle_after_reset", 64'(TX_D_VLD), 64'd0);
    rd_exp.push_back(8'h04);
    compare_all();
    tx_stall = 1'b0;
    do_write(4'h9, 8'h66);

    check("wr_rd_overlap", 64'(both_cnt), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmd_frame_ctrl.md
CMD_FRAME_CTRL -- requirements
Module: cmd_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: RX/TX word and register data width (>=8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: register file address width.
REQ-003 SHALL have parameter OUT_WORDS, default 2: ALU result width in DATA_WIDTH words.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024: idle cycles before an incomplete frame is dropped.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, as the first two ports below.
REQ-006 CLK  in  1  sole clock, rising edge.
REQ-007 RST  in  1  asynchronous reset, active low.
REQ-008 RX_P_DATA  in  DATA_WIDTH  received word, valid with RX_D_VLD.
REQ-009 RX_D_VLD  in  1  single-cycle received-word strobe.
REQ-010 ALU_OUT  in  OUT_WORDS*DATA_WIDTH  ALU result.
REQ-011 ALU_OUT_VLD  in  1  ALU result valid.
REQ-012 RdData  in  DATA_WIDTH  register read data.
REQ-013 RdData_VLD  in  1  read data valid.
REQ-014 Busy  in  1  transmitter busy, already synchronised to CLK.
REQ-015 ALU_FUN  out  4  ALU function select.
REQ-016 ALU_EN  out  1  ALU operation enable.
REQ-017 CLK_EN  out  1  ALU clock-gate enable.
REQ-018 Address  out  ADDR_WIDTH  register address.
REQ-019 WrEn  out  1  register write strobe.
REQ-020 RdEn  out  1  register read strobe.
REQ-021 WrData  out  DATA_WIDTH  register write data.
REQ-022 TX_P_DATA  out  DATA_WIDTH  word to transmit.
REQ-023 TX_D_VLD  out  1  transmit request.
REQ-024 CLK_div_en  out  1  TX clock divider enable.
REQ-025 Frame_error  out  1  single-cycle error pulse.

Function
REQ-026 Commands SHALL be decoded from RX_P_DATA[7:0] in IDLE, with upper bits required zero: 0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands.
REQ-027 Any other word received in IDLE SHALL be discarded, pulse Frame_error one cycle, and leave the state at IDLE.
REQ-028 States SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, OP_FUN, ALU_WAIT, TX_SEND, TX_HOLD.
REQ-029 Write, 0xAA -> WR_ADDR (latch Address) -> WR_DATA; on the data word, WrEn/WrData SHALL be valid one cycle, then IDLE.
REQ-030 Read, 0xBB -> RD_ADDR; on the address word, RdEn SHALL pulse one cycle, then RD_WAIT until RdData_VLD, latch RdData, then TX_SEND with 1 word.
REQ-031 ALU with operands, 0xCC -> OP_A -> OP_B -> OP_FUN; each operand word SHALL write register 0 (A) and register 1 (B) via a one-cycle WrEn.
REQ-032 ALU without operands, 0xDD -> OP_FUN.
REQ-033 In OP_FUN, the function word SHALL latch ALU_FUN = RX_P_DATA[3:0] and pulse ALU_EN one cycle.
REQ-034 CLK_EN SHALL assert on entry to OP_FUN and deassert on the cycle ALU_OUT_VLD is sampled in ALU_WAIT.
REQ-035 On ALU_OUT_VLD, ALU_OUT SHALL be latched and sent as OUT_WORDS words, least-significant word first.
REQ-036 TX handshake, TX_SEND: entered only with Busy=0; TX_D_VLD=1 and TX_P_DATA SHALL hold stable until Busy=1 is sampled, then TX_HOLD.
REQ-037 TX handshake, TX_HOLD: wait Busy=0; then either the next word (TX_SEND) or, after the last word, IDLE.
REQ-038 The word counter SHALL be ceil(log2(OUT_WORDS+1)) bits and SHALL wrap to 0 on return to IDLE.
REQ-039 RX_D_VLD received in RD_WAIT, ALU_WAIT, TX_SEND or TX_HOLD SHALL be ignored, with no Frame_error.
REQ-040 RdData_VLD or ALU_OUT_VLD arriving outside its wait state SHALL be ignored.
REQ-041 WrEn and RdEn SHALL never be asserted in the same cycle.

Reset
REQ-042 On RST low, the block SHALL enter IDLE immediately, including mid-frame or mid-transmission.
REQ-043 During reset, all outputs, counters and latched data SHALL be 0.
REQ-044 CLK_div_en SHALL be 1 from the first rising edge after RST deasserts.
REQ-045 The first frame SHALL be accepted on the first RX_D_VLD after RST deasserts.

Configuration
REQ-046 With macro CMD_TIMEOUT_EN defined: in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B and OP_FUN, a counter SHALL count cycles without RX_D_VLD and clear on RX_D_VLD.
REQ-047 With CMD_TIMEOUT_EN defined: at count TIMEOUT_CYCLES-1, the block SHALL return to IDLE and pulse Frame_error without issuing WrEn, RdEn or ALU_EN.
REQ-048 With CMD_TIMEOUT_EN defined: CLK_EN SHALL deassert if the timeout occurs in OP_FUN.
REQ-049 Without CMD_TIMEOUT_EN: no timeout logic SHALL exist, and the block SHALL wait indefinitely for frame words.

Verification
REQ-050 Write: RX 0xAA, 0x05, 0x3C -> one-cycle WrEn with Address=5 and WrData=0x3C; no TX.
REQ-051 Read: RX 0xBB, 0x02; RdData=0x7E with RdData_VLD two cycles after RdEn -> TX_P_DATA=0x7E held until Busy=1.
REQ-052 ALU: RX 0xCC, 0x0A, 0x03, 0x02, ALU_OUT=0x001E -> writes reg0=0x0A and reg1=0x03, ALU_FUN=2; TX 0x1E then 0x00, the second word only after Busy 1->0.
REQ-053 Unknown command: RX 0x55 -> one Frame_error pulse; state stays IDLE; a following 0xAA frame completes normally.
REQ-054 Timeout (CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16): RX 0xAA, 0x01, then silence -> Frame_error after 16 cycles, no WrEn; a following 0xBB frame decodes correctly.
REQ-055 Reset mid-TX: assert RST while TX_D_VLD=1 -> all outputs 0 asynchronously; after release CLK_div_en=1 and the state is IDLE.
